ecb_plain_packer: RTL and testbench



---
 rtl/ecb_pkg.sv | 19 +
 rtl/ecb_plain_packer.sv | 96 +++++++++
 tb/tb_ecb_plain_packer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ecb_pkg.sv
// Shared definitions for the ECB datapath blocks: byte width, packer FSM states, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ecb_pkg;

    localparam int BYTE_W = 8;

    // Packer FSM: FILL collects bytes, HOLD presents a finished word downstream.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pk_state_t;

    // Width needed to count 0..NBYTES bytes for a word of sync_size bits.
    function automatic int cnt_w(input int sync_size);
        return $clog2(sync_size / BYTE_W + 1);
    endfunction

endpackage

// File: rtl/ecb_plain_packer.sv
// Packs a byte stream little-endian into SYNC_SIZE-bit plaintext words; flush closes a zero-padded partial block.
// Latency: out_valid rises 1 cycle after the closing byte/flush handshake; in_ready returns 1 cycle after word transfer.
// Backpressure: no skid buffer; in_ready is low for the whole HOLD phase until out_ready takes the word.
module ecb_plain_packer
    import ecb_pkg::*;
#(
    parameter int SYNC_SIZE = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [BYTE_W-1:0]               in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic [SYNC_SIZE-1:0]            data_plain,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [cnt_w(SYNC_SIZE)-1:0]     out_len
);

    localparam int NBYTES = SYNC_SIZE / BYTE_W;
    localparam int CNT_W  = cnt_w(SYNC_SIZE);

    pk_state_t              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [SYNC_SIZE-1:0]   r_data;
    logic [CNT_W-1:0]       r_len;

    logic                   w_byte_acc;
    logic                   w_word_acc;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_close;
    logic [SYNC_SIZE-1:0]   w_data_next;

    // Handshakes and the byte count including any byte accepted this cycle.
    // A block closes when it fills, or on flush provided at least one real byte exists.
    always_comb begin
        w_byte_acc = in_valid && (r_state == FILL);
        w_word_acc = out_ready && (r_state == HOLD);
        w_cnt_next = r_cnt + CNT_W'(w_byte_acc);
        w_close    = (r_state == FILL) &&
                     ((w_cnt_next == CNT_W'(NBYTES)) || (flush && (w_cnt_next != '0)));
    end

    // Byte-lane write decoder: the accepted byte lands in the lane selected by the current count.
    always_comb begin
        w_data_next = r_data;
        for (int k = 0; k < NBYTES; k++) begin
            if (w_byte_acc && (r_cnt == CNT_W'(k))) begin
                w_data_next[k*BYTE_W +: BYTE_W] = in_data;
            end
        end
    end

    // Two-state FSM with counter, data and length registers; reset discards any partial or pending block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_data  <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    r_data <= w_data_next;
                    r_cnt  <= w_cnt_next;
                    if (w_close) begin
                        r_len   <= w_cnt_next;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // Word, length and count are frozen until the consumer takes the word.
                    if (w_word_acc) begin
                        r_data  <= '0;
                        r_cnt   <= '0;
                        r_len   <= '0;
                        r_state <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    // Outputs come straight from registers: no input-to-output combinational path.
    always_comb begin
        in_ready   = (r_state == FILL);
        out_valid  = (r_state == HOLD);
        data_plain = r_data;
        out_len    = r_len;
    end

endmodule

// File: tb/tb_ecb_plain_packer.sv
// Self-checking bench for ecb_plain_packer: directed scenarios plus randomized throttled traffic.
// Reference is a byte-queue model of the current block compared every cycle, plus an end-to-end byte stream scoreboard.
// Every wait is bounded; a global watchdog ends the run with a FAIL line if anything stalls.
module tb_ecb_plain_packer;

    localparam int SYNC_SIZE = 64;
    localparam int NB        = SYNC_SIZE / 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           in_data = 8'h00;
    logic                 in_valid = 1'b0;
    logic                 flush = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic [SYNC_SIZE-1:0] data_plain;
    logic [3:0]           out_len;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: bytes of the block being built/held, and whether it is being presented.
    logic       m_hold = 1'b0;
    logic [7:0] m_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] rcv_q[$];
    int         nsent;

    ecb_plain_packer #(.SYNC_SIZE(SYNC_SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .data_plain (data_plain),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_len    (out_len)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Little-endian image of the model's current block, zero padded.
    function automatic logic [63:0] m_word();
        logic [63:0] w = '0;
        for (int i = 0; i < m_q.size(); i++) w |= 64'(m_q[i]) << (8 * i);
        return w;
    endfunction

    // One clock: compare outputs at the falling edge, drive inputs, advance the model at the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic ordy);
        @(negedge clk);
        check("in_ready",   64'(in_ready),   64'(!m_hold));
        check("out_valid",  64'(out_valid),  64'(m_hold));
        check("data_plain", data_plain,      m_word());
        check("out_len",    64'(out_len),    m_hold ? 64'(m_q.size()) : 64'd0);
        if (out_valid && ordy)
            for (int i = 0; i < int'(out_len) && i < NB; i++) rcv_q.push_back(data_plain[8*i +: 8]);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        @(posedge clk);
        if (!m_hold) begin
            if (v) begin
                m_q.push_back(d);
                sent_q.push_back(d);
                nsent++;
            end
            if (m_q.size() == NB || (f && m_q.size() > 0)) m_hold = 1'b1;
        end else if (ordy) begin
            m_q.delete();
            m_hold = 1'b0;
        end
        #1;
    endtask

    // Asserts reset between clock edges and checks outputs clear before any edge arrives.
    task automatic async_reset(input string tag);
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check({tag, "_out_valid"},  64'(out_valid), 64'd0);
        check({tag, "_data_plain"}, data_plain,     64'd0);
        check({tag, "_out_len"},    64'(out_len),   64'd0);
        m_q.delete();
        m_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        nsent = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid",  64'(out_valid), 64'd0);
        check("rst_in_ready",   64'(in_ready),  64'd1);
        check("rst_data_plain", data_plain,     64'd0);
        check("rst_out_len",    64'(out_len),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: full block, back-to-back bytes, consumer always ready
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_word",  data_plain,     64'h0807060504030201);
        check("t1_len",   64'(out_len),   64'd8);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // 2: partial block closed by flush
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_word",  data_plain,     64'h0000000000CCBBAA);
        check("t2_len",   64'(out_len),   64'd3);

        // 3: held word stays put while input pushes changing bytes and flushes
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'b0);
        check("t3_word", data_plain, 64'h0000000000CCBBAA);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        check("t3_lane0", data_plain, 64'h000000000000005A);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // 4: empty flush ignored; flush with the 8th byte makes one block only
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_empty_flush", 64'(out_valid), 64'd0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h17, 1'b1, 1'b0);
        check("t4_len",  64'(out_len), 64'd8);
        check("t4_word", data_plain,   64'h1716151413121110);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t4_no_extra", 64'(out_valid), 64'd0);

        // 5: asynchronous reset mid-block and in HOLD, then a clean block
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        async_reset("t5a");
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        async_reset("t5b");
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        check("t5_clean_word", data_plain,   64'h5756555453525150);
        check("t5_clean_len",  64'(out_len), 64'd8);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // 6: random throttling and flushes, checked per cycle and as a byte stream
        sent_q.delete();
        rcv_q.delete();
        nsent = 0;
        for (int c = 0; c < 30000 && nsent < 1000; c++)
            step($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 60);
        check("t6_bytes_sent", 64'(nsent), 64'd1000);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_drained", 64'(out_valid), 64'd0);
        check("t6_stream_len", 64'(rcv_q.size()), 64'(sent_q.size()));
        for (int i = 0; i < sent_q.size() && i < rcv_q.size(); i++)
            check("t6_stream_byte", 64'(rcv_q[i]), 64'(sent_q[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
